md_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It consumes the two source operands read from the register file and returns one result per operation for the register-file write port. Each operation is a fixed-latency radix-2 shift-add multiply or restoring divide, one bit per cycle. The result is held under a valid/ready handshake so the writeback mux can arbitrate the single write port.

---
 rtl/md_pkg.sv | 22 ++
 rtl/md_unit.sv | 151 +++++++++++++++
 tb/tb_md_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op codes, FSM states and negate helper shared by md_unit
package md_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   // Widest value ever negated: the 2*DW product for DW up to 32.
   localparam int NEG_W = 64;

   function automatic logic [NEG_W-1:0] twos_neg(input logic [NEG_W-1:0] x);
      return ~x + NEG_W'(1);
   endfunction

endpackage

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative RV32M multiply/divide, one bit per cycle, valid/ready result
module md_unit
   import md_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [AW-1:0] rd,
   input  logic          flush,
   output logic          busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [AW-1:0] res_wa,
   output logic [DW-1:0] res_wd
);

   localparam int CW = $clog2(DW);
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [2:0]      op_r;
   logic            sign_a, sign_b;
   logic [2*DW-1:0] acc;    // multiply: product/multiplier; divide: low half is dividend/quotient
   logic [DW-1:0]   rem;
   logic [DW-1:0]   opb;    // multiplicand or divisor magnitude

   logic            a_signed, b_signed, sa_in, sb_in;
   logic [DW-1:0]   mag_a, mag_b;
   logic [DW:0]     mul_sum, div_shift, div_trial;
   logic [2*DW-1:0] prod;
   logic [DW-1:0]   quot, rmd, result;

   function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
      return DW'(twos_neg(NEG_W'(x)));
   endfunction

   always_comb begin
      a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      sa_in    = a_signed & a[DW-1];
      sb_in    = b_signed & b[DW-1];
      mag_a    = sa_in ? neg_dw(a) : a;
      mag_b    = sb_in ? neg_dw(b) : b;
   end

   always_comb begin
      mul_sum   = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opb} : '0);
      div_shift = {rem, acc[DW-1]};
      div_trial = div_shift - {1'b0, opb};
   end

   // Divide-by-zero and signed overflow fall out of the magnitude datapath except the
   // zero-divisor quotient, which sign correction would otherwise turn into +1.
   always_comb begin
      prod = (sign_a ^ sign_b) ? (2*DW)'(twos_neg(NEG_W'(acc))) : acc;
      if (opb == '0)
         quot = '1;
      else
         quot = (sign_a ^ sign_b) ? neg_dw(acc[DW-1:0]) : acc[DW-1:0];
      rmd = sign_a ? neg_dw(rem) : rem;
      case (op_r)
         OP_MUL:                       result = prod[DW-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*DW-1:DW];
         OP_DIV, OP_DIVU:              result = quot;
         default:                      result = rmd;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (flush)
         state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (cnt == CNT_LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            default: if (res_valid && res_ready) state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt       <= '0;
         op_r      <= '0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         acc       <= '0;
         rem       <= '0;
         opb       <= '0;
         res_valid <= 1'b0;
         res_wa    <= '0;
         res_wd    <= '0;
      end else if (flush) begin
         res_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               op_r   <= op;
               res_wa <= rd;
               sign_a <= sa_in;
               sign_b <= sb_in;
               opb    <= op[2] ? mag_b : mag_a;
               acc    <= {{DW{1'b0}}, (op[2] ? mag_a : mag_b)};
               rem    <= '0;
               cnt    <= '0;
            end
            CALC: begin
               cnt <= cnt + CW'(1);
               if (!op_r[2])
                  acc <= {mul_sum, acc[DW-1:1]};
               else if (!div_trial[DW]) begin
                  rem           <= div_trial[DW-1:0];
                  acc[DW-1:0]   <= {acc[DW-2:0], 1'b1};
               end else begin
                  rem           <= div_shift[DW-1:0];
                  acc[DW-1:0]   <= {acc[DW-2:0], 1'b0};
               end
            end
            FIX: res_wd <= result;
            default: begin
               // First DONE cycle raises valid; it drops on the accepting edge.
               if (!res_valid)
                  res_valid <= 1'b1;
               else if (res_ready)
                  res_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - randomized scoreboard bench for md_unit
module tb_md_unit;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;
   logic        busy, res_valid;
   logic        res_ready = 1'b0;
   logic [4:0]  res_wa;
   logic [31:0] res_wd;

   md_unit #(.DW(32), .AW(5)) dut (
      .clk(clk), .rstn(rstn), .start(start), .op(op), .a(a), .b(b), .rd(rd),
      .flush(flush), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
      .res_wa(res_wa), .res_wd(res_wd)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      int          c0;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   logic prev_v = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy;
      logic [63:0] ux, uy, p;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'd0, x};
      uy = {32'd0, y};
      p  = '0;
      case (o)
         3'd0: p = ux * uy;
         3'd1: p = sx * sy;
         3'd2: p = sx * $signed(uy);
         3'd3: p = ux * uy;
         default: ;
      endcase
      case (o)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: begin
            if (y == 0) return 32'hFFFF_FFFF;
            p = sx / sy;
            return p[31:0];
         end
         3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
         3'd6: begin
            if (y == 0) return x;
            p = sx % sy;
            return p[31:0];
         end
         default: return (y == 0) ? x : x % y;
      endcase
   endfunction

   // Monitor: latency on the rising edge of valid, data/address on each handshake.
   always @(negedge clk) begin
      if (!rstn)
         prev_v = 1'b0;
      else begin
         if (res_valid && !prev_v) begin
            if (q.size() == 0)
               chk("unexpected_result", 32'd1, 32'd0);
            else
               chk("latency", 32'(cyc - q[0].c0), 32'd34);
         end
         if (res_valid && res_ready && q.size() != 0) begin
            chk("res_wd", res_wd, q[0].wd);
            chk("res_wa", {27'd0, res_wa}, {27'd0, q[0].wa});
            void'(q.pop_front());
         end
         prev_v = res_valid;
      end
   end

   // Called aligned at posedge+1; returns aligned at posedge+1 after the accepting edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] e, input bit push);
      int t = 0;
      while (busy && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
      op = o; a = x; b = y; rd = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      if (push) q.push_back('{wa: r, wd: e, c0: cyc});
   endtask

   task automatic ack(input int dly);
      int t = 0;
      while (!res_valid && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 60) begin
         chk("valid_timeout", 32'd1, 32'd0);
         return;
      end
      repeat (dly) begin
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] r, input logic [31:0] e, input int dly);
      issue(o, x, y, r, e, 1'b1);
      ack(dly);
   endtask

   initial begin
      logic [2:0]  ro;
      logic [31:0] ra, rb, e;
      logic        seen_v;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_valid", {31'd0, res_valid}, 32'd0);
      chk("reset_wa", {27'd0, res_wa}, 32'd0);
      chk("reset_wd", res_wd, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB, 0);
      run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, 1);
      run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, 0);
      run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 2);
      run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 0);
      run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, 0);
      run(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'h7FFF_FFFC, 0);
      run(3'd4, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 0);
      run(3'd6, 32'd5, 32'd0, 5'd8, 32'd5, 0);
      run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 0);
      run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 0);

      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 7));
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            2: rb = 32'($urandom_range(1, 16));
            default: ;
         endcase
         run(ro, ra, rb, 5'($urandom_range(0, 31)), model(ro, ra, rb), int'($urandom_range(0, 3)));
      end

      // Backpressure: result held five cycles, a start in DONE is dropped.
      e = model(3'd0, 32'd1234, 32'd5678);
      issue(3'd0, 32'd1234, 32'd5678, 5'd17, e, 1'b1);
      begin
         int t = 0;
         while (!res_valid && t < 60) begin
            @(posedge clk); #1;
            t++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, res_valid}, 32'd1);
         chk("bp_wd", res_wd, e);
         chk("bp_wa", {27'd0, res_wa}, 32'd17);
         if (k == 2) begin
            op = 3'd5; a = 32'd99; b = 32'd3; rd = 5'd30; start = 1'b1;
         end else
            start = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      chk("bp_busy_after_ack", {31'd0, busy}, 32'd0);
      chk("bp_valid_after_ack", {31'd0, res_valid}, 32'd0);
      op = 3'd0; a = 32'd21; b = 32'd2; rd = 5'd12; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("bp_next_accept", {31'd0, busy}, 32'd1);
      q.push_back('{wa: 5'd12, wd: 32'd42, c0: cyc});
      ack(0);

      // Flush at CALC cycle 10, with a colliding start that must be ignored.
      issue(3'd4, 32'd100, 32'd7, 5'd20, 32'd0, 1'b0);
      repeat (10) begin
         @(posedge clk); #1;
      end
      flush = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      chk("flush_idle", {31'd0, busy}, 32'd0);
      seen_v = 1'b0;
      repeat (45) begin
         @(posedge clk); #1;
         seen_v = seen_v | res_valid;
      end
      chk("flush_no_valid", {31'd0, seen_v}, 32'd0);

      // Asynchronous reset mid-CALC.
      issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, 32'd0, 1'b0);
      repeat (8) begin
         @(posedge clk); #1;
      end
      #2 rstn = 1'b0;
      #1;
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_valid", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      run(3'd0, 32'd3, 32'd4, 5'd22, 32'd12, 1);

      begin
         int t = 0;
         while (q.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
         end
         if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
